// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   uart_state_e : frame state encoding (IDLE / START / DATA / STOP)
//   DBIT_DEF     : default number of data bits per frame
//   SB_TICK_DEF  : default oversampling ticks per stop bit (16 = 1 stop bit)
//   OVS          : oversampling ratio of the baud tick (ticks per bit)
//   TICK_W       : width of the per-bit tick counter
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVS         = 16;
  localparam int TICK_W      = 4;

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART serialiser driven by a 16x oversampling baud tick.
//
// Sends one start bit (0), DBIT data bits LSB first, then a stop bit (1) of
// SB_TICK ticks. The baud tick comes from a generator outside this block.
//
// Parameters:
//   DBIT    : data bits per frame
//   SB_TICK : ticks in the stop bit (16 = one stop bit)
//
// Ports:
//   i_clk      : system clock
//   i_reset_n  : asynchronous active-low reset
//   i_tick     : 16x baud tick, one i_clk cycle wide
//   i_tx_start : request to send i_data (only honoured in IDLE)
//   i_data     : word to transmit, captured on the accepting edge
//   o_tx       : registered serial line, idle high
//   o_tx_done  : one-cycle pulse in the final cycle of the stop bit
//   o_busy     : high whenever a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_busy
);

  localparam int                NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0]     LAST_BIT  = NW'(DBIT - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVS - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);

  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] s_q, s_d;     // ticks elapsed within the current bit
  logic [NW-1:0]     n_q, n_d;     // index of the data bit on the line
  logic [DBIT-1:0]   b_q, b_d;     // shift register, LSB is next to send
  logic              tx_q, tx_d;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the state being entered,
  // so the line changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    tx_d      = tx_q;
    o_tx_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // A tick in the accepting cycle is deliberately not counted.
        if (i_tx_start) begin
          state_d = START;
          s_d     = '0;
          b_d     = i_data;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (i_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == LAST_BIT) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              n_d  = n_q + 1'b1;
              tx_d = b_d[0];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (s_q == STOP_LAST) begin
            // Done is flagged while still in STOP, so a start request in this
            // cycle cannot be accepted; the next IDLE cycle takes it.
            state_d   = IDLE;
            s_d       = '0;
            o_tx_done = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// The baud tick is produced here with a short divisor so each frame spans a
// few hundred clocks (the system uses 326 at 50 MHz for 9600 baud). A monitor
// records the line level at every tick edge while the transmitter is busy;
// each frame must then show 16 samples per bit, and the byte is recovered
// from the mid-bit samples as a receiver would.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DIV  = 4;
  localparam int NBUF = 8192;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       i_tick     = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_data     = 8'h00;
  logic       o_tx;
  logic       o_tx_done;
  logic       o_busy;

  always #10 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_tick     (i_tick),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .o_busy     (o_busy)
  );

  int   n_chk    = 0;
  int   n_fail   = 0;
  bit   tick_en  = 1'b0;
  int   tcnt     = 0;
  logic samp [0:NBUF-1];
  int   samp_cnt = 0;
  int   done_cnt = 0;

  // Line monitor: values seen at the clock edge are the pre-edge levels.
  always @(posedge clk) begin
    if (rst_n && o_busy && i_tick && samp_cnt < NBUF) begin
      samp[samp_cnt] = o_tx;
      samp_cnt++;
    end
    if (o_tx_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;   // bit k = level of frame bit k (0 = start, 9 = stop)
    logic [7:0] rxb;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_en) begin
      tcnt   = (tcnt == DIV - 1) ? 0 : tcnt + 1;
      i_tick = (tcnt == DIV - 1);
    end else begin
      i_tick = 1'b0;
    end
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (o_busy && k < 4000) begin
      step();
      k++;
    end
    check({name, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic wait_samples(input string name, input int base, input int n);
    int k = 0;
    while ((samp_cnt - base) < n && k < 4000) begin
      step();
      k++;
    end
    check({name, "_reached"}, 32'((samp_cnt - base) >= n), 32'd1);
  endtask

  task automatic send(input string name, input logic [7:0] d);
    i_data     = d;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check({name, "_accept_tx"},   32'(o_tx),   32'd0);
    check({name, "_accept_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic check_frame(input string name, input int base, input logic [9:0] line,
                             input logic [7:0] rxb, input int exp_cnt);
    int         bad = -1;
    logic [7:0] dec;
    for (int k = 0; k < 160; k++) begin
      if (bad < 0 && samp[base + k] !== line[k / 16]) bad = k;
    end
    for (int i = 0; i < 8; i++) dec[i] = samp[base + 16 * (i + 1) + 8];
    check({name, "_nsamp"},   32'(samp_cnt - base), 32'(exp_cnt));
    check({name, "_first_bad_sample"}, 32'(bad), 32'hFFFF_FFFF);
    check({name, "_rxbyte"},  32'(dec), 32'(rxb));
  endtask

  initial begin
    int base;
    int d0;
    int sc;
    int k;
    bit stable;
    logic tx0;

    vt[0] = '{din: 8'h55, line: 10'h2AA, rxb: 8'h55};
    vt[1] = '{din: 8'hA3, line: 10'h346, rxb: 8'hA3};
    vt[2] = '{din: 8'h00, line: 10'h200, rxb: 8'h00};
    vt[3] = '{din: 8'hFF, line: 10'h3FE, rxb: 8'hFF};
    vt[4] = '{din: 8'h0F, line: 10'h21E, rxb: 8'h0F};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_tx",   32'(o_tx),      32'd1);
    check("reset_busy", 32'(o_busy),    32'd0);
    check("reset_done", 32'(o_tx_done), 32'd0);
    rst_n   = 1'b1;
    tick_en = 1'b1;
    step();

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      base = samp_cnt;
      d0   = done_cnt;
      send($sformatf("vec%0d", i), vt[i].din);
      wait_idle($sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), base, vt[i].line, vt[i].rxb, 160);
      check($sformatf("vec%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
      step();
    end

    // Start request and data changes during a frame are ignored
    base = samp_cnt;
    d0   = done_cnt;
    send("ign", 8'h55);
    i_data = 8'hAA;
    wait_samples("ign", base, 70);
    i_tx_start = 1'b1;
    i_data     = 8'h0F;
    step();
    i_tx_start = 1'b0;
    i_data     = 8'hC3;
    wait_idle("ign");
    check_frame("ign", base, 10'h2AA, 8'h55, 160);
    check("ign_done_pulses", 32'(done_cnt - d0), 32'd1);
    repeat (5) step();
    check("ign_no_second_frame", 32'(o_busy), 32'd0);

    // Tick coincident with the accepting cycle is not counted
    tick_en = 1'b0;
    step();
    base       = samp_cnt;
    d0         = done_cnt;
    i_tick     = 1'b1;
    i_data     = 8'h0F;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    check("cotick_accept_tx", 32'(o_tx), 32'd0);
    tcnt    = 0;
    tick_en = 1'b1;
    wait_idle("cotick");
    check_frame("cotick", base, 10'h21E, 8'h0F, 160);
    check("cotick_done_pulses", 32'(done_cnt - d0), 32'd1);
    step();

    // Tick held low freezes the frame
    base = samp_cnt;
    d0   = done_cnt;
    send("frz", 8'hA3);
    wait_samples("frz", base, 40);
    tick_en = 1'b0;
    step();
    tx0    = o_tx;
    sc     = done_cnt;
    stable = 1'b1;
    repeat (50) begin
      step();
      if (o_tx !== tx0 || o_busy !== 1'b1) stable = 1'b0;
    end
    check("frz_stable", 32'(stable), 32'd1);
    check("frz_no_done", 32'(done_cnt - sc), 32'd0);
    tick_en = 1'b1;
    wait_idle("frz");
    check_frame("frz", base, 10'h346, 8'hA3, 160);
    check("frz_done_pulses", 32'(done_cnt - d0), 32'd1);
    step();

    // Asynchronous reset during data bit 3, then a clean frame
    base = samp_cnt;
    d0   = done_cnt;
    send("rst", 8'h55);
    wait_samples("rst", base, 16 * 4 + 4);
    #5;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx",   32'(o_tx),      32'd1);
    check("rst_async_busy", 32'(o_busy),    32'd0);
    check("rst_async_done", 32'(o_tx_done), 32'd0);
    repeat (3) step();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    base  = samp_cnt;
    d0    = done_cnt;
    send("post_rst", 8'hFF);
    wait_idle("post_rst");
    check_frame("post_rst", base, 10'h3FE, 8'hFF, 160);
    check("post_rst_done_pulses", 32'(done_cnt - d0), 32'd1);
    step();

    // Start held high: back-to-back frames with a single idle cycle
    base       = samp_cnt;
    d0         = done_cnt;
    i_data     = 8'hA3;
    i_tx_start = 1'b1;
    step();
    check("b2b_accept_tx", 32'(o_tx), 32'd0);
    k = 0;
    while (!o_tx_done && k < 2000) begin
      step();
      k++;
    end
    check("b2b_done_seen", 32'(o_tx_done), 32'd1);
    check("b2b_done_still_busy", 32'(o_busy), 32'd1);
    step();
    check("b2b_gap_busy", 32'(o_busy), 32'd0);
    check("b2b_gap_tx",   32'(o_tx),   32'd1);
    step();
    check("b2b_restart_busy", 32'(o_busy), 32'd1);
    check("b2b_restart_tx",   32'(o_tx),   32'd0);
    i_tx_start = 1'b0;
    wait_idle("b2b");
    check_frame("b2b_f1", base, 10'h346, 8'hA3, 320);
    check_frame("b2b_f2", base + 160, 10'h346, 8'hA3, 160);
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
